mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, byte-addressed memory between the instruction
//   fetch requester (IF) and the data requester (MEM stage). Each access
//   holds the memory for LAT cycles, then a one-cycle DONE state pulses the
//   matching ready line and arbitrates the next transaction.
//
// Parameters
//   LAT            memory access cycles per transaction (1..15)
//   MAX_DATA_BURST data grants allowed while IF waits before IF wins (1..15)
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ready) and address
//   if_rdata/if_ready         fetched word and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, data
//   dm_rdata/dm_ready         load data and its one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   stall_if/stall_mem        requester waiting and not completing this cycle
//   busy                      arbiter is not idle
module mem_port_arbiter #(
  parameter int LAT            = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam logic [3:0] MAX_B  = 4'(MAX_DATA_BURST);

  typedef enum logic [2:0] {
    IDLE,
    ACC_I,
    ACC_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  burst;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        if_cand;
  logic        dm_cand;
  logic        grant_if;
  logic        grant_dm;

  // Arbitration. The requester that just finished is ignored in its own
  // DONE state because its req line still belongs to the old transaction.
  // Data normally wins; IF wins once it has waited out MAX_DATA_BURST data
  // grants.
  always_comb begin
    if_cand  = if_req && ((state == IDLE) || (state == DONE_D));
    dm_cand  = dm_req && ((state == IDLE) || (state == DONE_I));
    grant_if = if_cand && (!dm_cand || (burst == MAX_B));
    grant_dm = dm_cand && !grant_if;
  end

  // Transaction sequencer: grant, LAT access cycles, one DONE cycle.
  // Address, write enable and write data are latched on grant so the
  // requesters may change their inputs once ready has pulsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      burst    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      case (state)
        IDLE, DONE_I, DONE_D: begin
          if (grant_if) begin
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            burst   <= '0;
            cnt     <= LAT_M1;
            state   <= ACC_I;
          end else if (grant_dm) begin
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
            // Count data grants that overtook a waiting fetch.
            if (if_req)
              burst <= (burst == MAX_B) ? burst : burst + 4'd1;
            else
              burst <= '0;
            cnt     <= LAT_M1;
            state   <= ACC_D;
          end else begin
            state <= IDLE;
          end
        end
        ACC_I: begin
          if (cnt == 4'd0) begin
            if_rdata <= mem_rdata;
            state    <= DONE_I;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACC_D: begin
          if (cnt == 4'd0) begin
            if (!we_q)
              dm_rdata <= mem_rdata;
            state <= DONE_D;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state and latched request fields.
  // mem_we is qualified with the access states so it never leaks into DONE.
  always_comb begin
    mem_en    = (state == ACC_I) || (state == ACC_D);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ready  = (state == DONE_I);
    dm_ready  = (state == DONE_D);
    busy      = (state != IDLE);
    stall_if  = if_req && !if_ready;
    stall_mem = dm_req && !dm_ready;
  end

endmodule
